// File: rtl/div_if.sv
// Handshake and operand bundle between the issuing pipeline (master) and div_unit (slave).
interface div_if;
    logic        start_i;
    logic        kill_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    modport master (
        output start_i, kill_i, op_i, dividend_i, divisor_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, kill_i, op_i, dividend_i, divisor_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit RISC-V style divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow on the accepting edge.
module div_unit (
    input  logic   clk_i,
    input  logic   rst_n_i,
    div_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic        sel_rem_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [31:0] result_q;

    logic [32:0] shifted_s;
    logic [32:0] diff_s;
    logic        ge_s;
    logic [31:0] rem_nxt_s;
    logic [31:0] quo_nxt_s;
    logic [31:0] final_s;
    logic        is_signed_s;

    // Two's complement magnitude; 0x80000000 maps to itself and is then read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        logic [31:0] m;
        if (sgn && x[31]) begin
            m = 32'd0 - x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    assign is_signed_s = ~bus.op_i[0];

    // One restoring step; a set bit 32 of the shifted value means it already exceeds any divisor.
    always_comb begin
        shifted_s = {rem_q, quo_q[31]};
        diff_s    = shifted_s - {1'b0, dvs_q};
        ge_s      = shifted_s[32] | ~diff_s[32];
        rem_nxt_s = shifted_s[31:0];
        if (ge_s) begin
            rem_nxt_s = diff_s[31:0];
        end else begin
            rem_nxt_s = shifted_s[31:0];
        end
        quo_nxt_s = {quo_q[30:0], ge_s};
        final_s   = quo_nxt_s;
        if (sel_rem_q) begin
            if (neg_rem_q) begin
                final_s = 32'd0 - rem_nxt_s;
            end else begin
                final_s = rem_nxt_s;
            end
        end else begin
            if (neg_quo_q) begin
                final_s = 32'd0 - quo_nxt_s;
            end else begin
                final_s = quo_nxt_s;
            end
        end
    end

    // Control FSM and datapath registers; kill_i overrides everything including start_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 32'd0;
        end else if (bus.kill_i) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        cnt_q     <= 5'd0;
                        quo_q     <= mag32(bus.dividend_i, is_signed_s);
                        rem_q     <= 32'd0;
                        dvs_q     <= mag32(bus.divisor_i, is_signed_s);
                        sel_rem_q <= bus.op_i[1];
                        neg_quo_q <= is_signed_s & (bus.dividend_i[31] ^ bus.divisor_i[31])
                                     & (bus.divisor_i != 32'd0);
                        neg_rem_q <= is_signed_s & bus.dividend_i[31];
`ifdef DIV_EARLY_OUT_EN
                        if (bus.divisor_i == 32'd0) begin
                            result_q <= bus.op_i[1] ? bus.dividend_i : 32'hFFFF_FFFF;
                            state_q  <= DONE;
                        end else if (is_signed_s && (bus.dividend_i == 32'h8000_0000)
                                     && (bus.divisor_i == 32'hFFFF_FFFF)) begin
                            result_q <= bus.op_i[1] ? 32'd0 : 32'h8000_0000;
                            state_q  <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    quo_q <= quo_nxt_s;
                    rem_q <= rem_nxt_s;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= final_s;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.valid_o  = (state_q == DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor pops on valid_o.
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    logic clk_i;
    logic rst_n_i;
    div_if bus ();

    exp_t sb_q[$];
    int   checks;
    int   errors;
    int   edge_cnt;

    div_unit u_dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Posedge counter used to measure accept-to-valid latency.
    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every valid_o pulse must match the scoreboard head and last exactly one cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (bus.valid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", bus.result_o, 32'hxxxx_xxxx);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", bus.result_o, e.res);
                    chk("latency", 32'(edge_cnt - e.acc + 1), 32'(e.lat));
                end
                @(negedge clk_i);
                chk("valid_width", {31'd0, bus.valid_o}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input bit special, input bit expect_it);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk_i);
        while (bus.busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (bus.busy_o) chk("issue_timeout", 32'd1, 32'd0);
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        if (expect_it) begin
            e.res = res;
            e.acc = edge_cnt;
            e.lat = special ? SPECIAL_LAT : 33;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.busy_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        edge_cnt       = 0;
        rst_n_i        = 1'b0;
        bus.start_i    = 1'b0;
        bus.kill_i     = 1'b0;
        bus.op_i       = 2'b00;
        bus.dividend_i = 32'd0;
        bus.divisor_i  = 32'd0;
        #3;
        chk("rst_busy",   {31'd0, bus.busy_o},  32'd0);
        chk("rst_valid",  {31'd0, bus.valid_o}, 32'd0);
        chk("rst_result", bus.result_o,         32'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Plain quotients and remainders, back to back
        issue(OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, 1'b1);
        issue(OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0, 1'b1);
        issue(OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 1'b1);
        issue(OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b1);
        issue(OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 1'b1);
        issue(OP_DIV,  32'h8000_0000,  32'd3,          32'hD555_5556,  1'b0, 1'b1);
        issue(OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  1'b0, 1'b1);
        issue(OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1);
        issue(OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1);
        issue(OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 1'b1);
        // Divide by zero and signed overflow
        issue(OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1, 1'b1);
        issue(OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1, 1'b1);
        issue(OP_REM,  32'h8765_4321,  32'd0,          32'h8765_4321,  1'b1, 1'b1);
        issue(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1'b1);
        issue(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1);
        wait_done();

        // A start pulse while busy must not disturb the running operation
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        bus.op_i = OP_DIV; bus.dividend_i = 32'd1; bus.divisor_i = 32'd1; bus.start_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        wait_done();

        // Kill at iteration 10, then kill beating start in IDLE
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        bus.kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("kill_busy", {31'd0, bus.busy_o}, 32'd0);
        bus.kill_i = 1'b0;
        @(negedge clk_i);
        bus.op_i = OP_DIVU; bus.dividend_i = 32'd9; bus.divisor_i = 32'd3;
        bus.start_i = 1'b1; bus.kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("kill_over_start", {31'd0, bus.busy_o}, 32'd0);
        bus.start_i = 1'b0; bus.kill_i = 1'b0;
        repeat (40) @(negedge clk_i);
        issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1);
        wait_done();

        // Asynchronous reset mid-operation; start accepted on the first edge after release
        issue(OP_DIVU, 32'd50, 32'd5, 32'd0, 1'b0, 1'b0);
        repeat (8) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_busy",   {31'd0, bus.busy_o},  32'd0);
        chk("arst_valid",  {31'd0, bus.valid_o}, 32'd0);
        chk("arst_result", bus.result_o,         32'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        bus.op_i = OP_DIVU; bus.dividend_i = 32'd20; bus.divisor_i = 32'd4;
        bus.start_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        sb_q.push_back('{32'd5, edge_cnt, 33});
        wait_done();
        repeat (5) @(negedge clk_i);
        chk("final_idle", {31'd0, bus.busy_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
